// File: rtl/nn_param_loader_if.sv
// nn_param_loader_if: parameter word handshake plus the shared layer configuration bus.
interface nn_param_loader_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       config_layer_num;
    logic [31:0]       config_neuron_num;
    logic [DATA_W-1:0] weightValue;
    logic              weightValid;
    logic [DATA_W-1:0] biasValue;
    logic              biasValid;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [31:0]       word_count;

    modport master (
        output start, abort, in_data, in_valid,
        input  in_ready, config_layer_num, config_neuron_num, weightValue, weightValid,
        input  biasValue, biasValid, busy, done, aborted, word_count
    );

    modport slave (
        input  start, abort, in_data, in_valid,
        output in_ready, config_layer_num, config_neuron_num, weightValue, weightValid,
        output biasValue, biasValid, busy, done, aborted, word_count
    );
endinterface

// File: rtl/nn_param_loader.sv
// nn_param_loader: walks layer/neuron/word indices over a flat parameter stream and
// strobes bias/weight words into the layer config bus one cycle after each accept.
module nn_param_loader #(
    parameter int DATA_W = 32,
    parameter int L1_NN  = 30,
    parameter int L1_NW  = 784,
    parameter int L2_NN  = 30,
    parameter int L2_NW  = 30,
    parameter int L3_NN  = 10,
    parameter int L3_NW  = 30,
    parameter int L4_NN  = 10,
    parameter int L4_NW  = 10
) (
    input logic clk,
    input logic rst,
    nn_param_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BIAS, WEIGHT, DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       layer_q, layer_d, neuron_q, neuron_d, widx_q, widx_d;
    logic [31:0]       word_count_q, word_count_d;
    logic [31:0]       cfg_layer_q, cfg_layer_d, cfg_neuron_q, cfg_neuron_d;
    logic [DATA_W-1:0] weight_value_q, weight_value_d, bias_value_q, bias_value_d;
    logic              weight_valid_q, weight_valid_d, bias_valid_q, bias_valid_d;
    logic              done_q, done_d, aborted_q, aborted_d;
    logic [31:0]       nn, nw;
    logic              active, accept, last_w, last_n;

    assign active       = state_q == BIAS || state_q == WEIGHT;
    assign bus.in_ready = active && !bus.abort;
    assign accept       = bus.in_valid && bus.in_ready;
    assign nn = layer_q == 32'd1 ? 32'(L1_NN) : layer_q == 32'd2 ? 32'(L2_NN) :
                layer_q == 32'd3 ? 32'(L3_NN) : 32'(L4_NN);
    assign nw = layer_q == 32'd1 ? 32'(L1_NW) : layer_q == 32'd2 ? 32'(L2_NW) :
                layer_q == 32'd3 ? 32'(L3_NW) : 32'(L4_NW);
    assign last_w = widx_q == nw - 32'd1;
    assign last_n = neuron_q == nn - 32'd1;

    always_comb begin
        state_d        = state_q;
        layer_d        = layer_q;
        neuron_d       = neuron_q;
        widx_d         = widx_q;
        word_count_d   = word_count_q;
        cfg_layer_d    = cfg_layer_q;
        cfg_neuron_d   = cfg_neuron_q;
        weight_value_d = weight_value_q;
        bias_value_d   = bias_value_q;
        weight_valid_d = 1'b0;
        bias_valid_d   = 1'b0;
        done_d         = state_q == DONE;
        aborted_d      = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d      = BIAS;
                layer_d      = 32'd1;
                neuron_d     = '0;
                widx_d       = '0;
                word_count_d = '0;
            end
            BIAS, WEIGHT: if (bus.abort) begin
                state_d   = IDLE;
                aborted_d = 1'b1;
                layer_d   = '0;
                neuron_d  = '0;
                widx_d    = '0;
            end else if (accept) begin
                word_count_d = word_count_q + 32'd1;
                // Tags are captured with the word so they stay aligned with its strobe.
                cfg_layer_d  = layer_q;
                cfg_neuron_d = neuron_q;
                if (state_q == BIAS) begin
                    bias_value_d = bus.in_data;
                    bias_valid_d = 1'b1;
                    state_d      = WEIGHT;
                end else begin
                    weight_value_d = bus.in_data;
                    weight_valid_d = 1'b1;
                    widx_d         = last_w ? '0 : widx_q + 32'd1;
                    if (last_w) begin
                        neuron_d = last_n ? '0 : neuron_q + 32'd1;
                        layer_d  = last_n ? layer_q + 32'd1 : layer_q;
                        state_d  = last_n && layer_q == 32'd4 ? DONE : BIAS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            layer_q        <= '0;
            neuron_q       <= '0;
            widx_q         <= '0;
            word_count_q   <= '0;
            cfg_layer_q    <= '0;
            cfg_neuron_q   <= '0;
            weight_value_q <= '0;
            bias_value_q   <= '0;
            weight_valid_q <= 1'b0;
            bias_valid_q   <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            layer_q        <= layer_d;
            neuron_q       <= neuron_d;
            widx_q         <= widx_d;
            word_count_q   <= word_count_d;
            cfg_layer_q    <= cfg_layer_d;
            cfg_neuron_q   <= cfg_neuron_d;
            weight_value_q <= weight_value_d;
            bias_value_q   <= bias_value_d;
            weight_valid_q <= weight_valid_d;
            bias_valid_q   <= bias_valid_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
        end
    end

    assign bus.config_layer_num  = cfg_layer_q;
    assign bus.config_neuron_num = cfg_neuron_q;
    assign bus.weightValue       = weight_value_q;
    assign bus.weightValid       = weight_valid_q;
    assign bus.biasValue         = bias_value_q;
    assign bus.biasValid         = bias_valid_q;
    assign bus.busy              = active;
    assign bus.done              = done_q;
    assign bus.aborted           = aborted_q;
    assign bus.word_count        = word_count_q;
endmodule

// File: tb/tb_nn_param_loader.sv
// tb_nn_param_loader: randomized-data scenarios on a reduced 2x3/1x2/1x2/1x2 network,
// checked against an expected stream order built from nested layer/neuron/word loops.
module tb_nn_param_loader;
    localparam int DW = 32;
    localparam int NN [4] = '{2, 1, 1, 1};
    localparam int NW [4] = '{3, 2, 2, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   total = 0;
    bit          exp_bias [$];
    logic [31:0] exp_layer [$];
    logic [31:0] exp_neuron [$];
    logic [31:0] words [$];

    always #5 clk = ~clk;

    nn_param_loader_if #(.DATA_W(DW)) bus ();

    nn_param_loader #(
        .DATA_W(DW), .L1_NN(2), .L1_NW(3), .L2_NN(1), .L2_NW(2),
        .L3_NN(1), .L3_NW(2), .L4_NN(1), .L4_NW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic void build_model();
        for (int l = 0; l < 4; l++)
            for (int n = 0; n < NN[l]; n++)
                for (int w = 0; w <= NW[l]; w++) begin
                    exp_bias.push_back(w == 0);
                    exp_layer.push_back(32'(l + 1));
                    exp_neuron.push_back(32'(n));
                end
        total = exp_bias.size();
    endfunction

    task automatic new_words();
        words.delete();
        for (int i = 0; i < total; i++) words.push_back($urandom);
    endtask

    task automatic step(input logic s, input logic a, input logic v, input logic [31:0] d,
                        output logic acc);
        bus.start = s;
        bus.abort = a;
        bus.in_valid = v;
        bus.in_data = d;
        #1;
        acc = v && bus.in_ready;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in_data = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.busy, bus.in_ready, bus.weightValid, bus.biasValid, bus.done, bus.aborted} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000",
                     {bus.busy, bus.in_ready, bus.weightValid, bus.biasValid, bus.done, bus.aborted});
        end
        vectors++;
        if ({bus.word_count, bus.config_layer_num, bus.config_neuron_num} !== 96'b0) begin
            miscompares++;
            $display("FAIL reset_counts: got wc=%0d layer=%0d neuron=%0d want 0", bus.word_count,
                     bus.config_layer_num, bus.config_neuron_num);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_in_ready: got %b want 0", bus.in_ready);
        end
    endtask

    task automatic test_load(input bit throttle, input bit restart);
        logic acc;
        bit   s, sent = 0;
        int   k = 0, cyc = 0;
        new_words();
        step(1, 0, 0, '0, acc);
        vectors++;
        if (bus.busy !== 1'b1 || bus.word_count !== 32'd0) begin
            miscompares++;
            $display("FAIL start_busy: got busy=%b wc=%0d want 1/0", bus.busy, bus.word_count);
        end
        while (k < total && cyc < 200) begin
            s = restart && k == 4 && !sent;
            sent |= s;
            step(s, 0, throttle ? cyc % 2 == 0 : 1'b1, words[k], acc);
            cyc++;
            vectors++;
            if (acc) begin
                if ({bus.biasValid, bus.weightValid} !== (exp_bias[k] ? 2'b10 : 2'b01)) begin
                    miscompares++;
                    $display("FAIL strobe_kind word %0d: got bv/wv=%b%b want bias=%0d", k + 1,
                             bus.biasValid, bus.weightValid, exp_bias[k]);
                end
                vectors++;
                if ((exp_bias[k] ? bus.biasValue : bus.weightValue) !== words[k]) begin
                    miscompares++;
                    $display("FAIL strobe_value word %0d: got %h/%h want %h", k + 1,
                             bus.biasValue, bus.weightValue, words[k]);
                end
                vectors++;
                if (bus.config_layer_num !== exp_layer[k] || bus.config_neuron_num !== exp_neuron[k]) begin
                    miscompares++;
                    $display("FAIL tag word %0d: got (%0d,%0d) want (%0d,%0d)", k + 1,
                             bus.config_layer_num, bus.config_neuron_num, exp_layer[k], exp_neuron[k]);
                end
                k++;
            end else if ({bus.biasValid, bus.weightValid} !== 2'b00) begin
                miscompares++;
                $display("FAIL spurious_strobe cycle %0d: got %b%b want 00", cyc,
                         bus.biasValid, bus.weightValid);
            end
        end
        vectors++;
        if (k != total) begin
            miscompares++;
            $display("FAIL load_timeout: got %0d accepts want %0d", k, total);
        end
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL early_done: got %b want 0", bus.done);
        end
        step(1, 0, 0, '0, acc);
        vectors++;
        if ({bus.done, bus.busy, bus.biasValid, bus.weightValid} !== 4'b1000 || bus.word_count !== 32'(total)) begin
            miscompares++;
            $display("FAIL done_pulse: got done/busy/bv/wv=%b%b%b%b wc=%0d want 1000 wc=%0d", bus.done,
                     bus.busy, bus.biasValid, bus.weightValid, bus.word_count, total);
        end
        step(0, 0, 1, '0, acc);
        vectors++;
        if ({bus.done, bus.busy, bus.in_ready} !== 3'b000 || bus.word_count !== 32'(total)) begin
            miscompares++;
            $display("FAIL after_done: got done/busy/rdy=%b%b%b wc=%0d want 000 wc=%0d", bus.done,
                     bus.busy, bus.in_ready, bus.word_count, total);
        end
    endtask

    task automatic test_abort();
        logic acc;
        new_words();
        step(1, 0, 0, '0, acc);
        for (int k = 0; k < 6; k++) step(0, 0, 1, words[k], acc);
        vectors++;
        if (bus.weightValid !== 1'b1 || bus.weightValue !== words[5]) begin
            miscompares++;
            $display("FAIL word6_strobe: got wv=%b %h want 1 %h", bus.weightValid, bus.weightValue, words[5]);
        end
        step(0, 1, 1, words[6], acc);
        vectors++;
        if (acc !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_accept: got %b want 0", acc);
        end
        vectors++;
        if ({bus.aborted, bus.busy, bus.biasValid, bus.weightValid, bus.done} !== 5'b10000 || bus.word_count !== 32'd6) begin
            miscompares++;
            $display("FAIL abort_pulse: got ab/busy/bv/wv/done=%b%b%b%b%b wc=%0d want 10000 wc=6",
                     bus.aborted, bus.busy, bus.biasValid, bus.weightValid, bus.done, bus.word_count);
        end
        step(0, 0, 1, '0, acc);
        vectors++;
        if ({bus.aborted, bus.in_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL post_abort: got ab/rdy=%b%b want 00", bus.aborted, bus.in_ready);
        end
        step(0, 1, 0, '0, acc);
        vectors++;
        if ({bus.aborted, bus.busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_abort: got ab/busy=%b%b want 00", bus.aborted, bus.busy);
        end
        step(1, 1, 0, '0, acc);
        vectors++;
        if ({bus.aborted, bus.busy} !== 2'b01 || bus.word_count !== 32'd0) begin
            miscompares++;
            $display("FAIL start_beats_abort: got ab/busy=%b%b wc=%0d want 01 wc=0", bus.aborted,
                     bus.busy, bus.word_count);
        end
        step(0, 1, 0, '0, acc);
        vectors++;
        if ({bus.aborted, bus.busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL abort_in_bias: got ab/busy=%b%b want 10", bus.aborted, bus.busy);
        end
        step(0, 0, 0, '0, acc);
    endtask

    task automatic test_reset_midload();
        logic acc;
        new_words();
        step(1, 0, 0, '0, acc);
        for (int k = 0; k < 10; k++) step(0, 0, 1, words[k], acc);
        vectors++;
        if (bus.word_count !== 32'd10) begin
            miscompares++;
            $display("FAIL pre_reset_count: got %0d want 10", bus.word_count);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.in_ready, bus.weightValid, bus.biasValid, bus.done, bus.aborted} !== 6'b0 ||
            {bus.word_count, bus.config_layer_num, bus.config_neuron_num} !== 96'b0) begin
            miscompares++;
            $display("FAIL async_reset: got flags=%b wc=%0d layer=%0d want all 0",
                     {bus.busy, bus.in_ready, bus.weightValid, bus.biasValid, bus.done, bus.aborted},
                     bus.word_count, bus.config_layer_num);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, words[10], acc);
            vectors++;
            if ({acc, bus.busy, bus.done, bus.aborted} !== 4'b0000 || bus.word_count !== 32'd0) begin
                miscompares++;
                $display("FAIL post_reset_idle: got acc/busy/done/ab=%b%b%b%b wc=%0d want 0000 wc=0",
                         acc, bus.busy, bus.done, bus.aborted, bus.word_count);
            end
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_load(0, 0);
        test_load(1, 0);
        test_abort();
        test_load(0, 0);
        test_load(0, 1);
        test_load(1, 1);
        test_reset_midload();
        test_load(0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
